mc_datapath_ws: RTL and testbench
=================================

// Module: mc_datapath_ws
// PURPOSE
//  Parametrised multicycle datapath for the ARM-subset core, with a wait-state memory handshake.
//  Holds PC, instruction, data, A/B and ALUOut state registers, the register file and the ALU.
//  Sits between the multicycle controller and the unified memory. Any access may take N>=1 cycles.
//  Asserts Stall so the controller freezes its state. Asserts a sticky BusErr after a bounded wait.
// PARAMETERS
//  XLEN      32   datapath width; >=16
//  NREG      16   architectural registers; index width RW=$clog2(NREG); reg NREG-1 is the PC alias
//  RESET_PC  0    PC value after reset
//  MAX_WAIT  15   stalled cycles tolerated per access before BusErr; counter width $clog2(MAX_WAIT+1)
// PORTS
//  clk         in   1      clock, rising edge
//  reset       in   1      asynchronous, active-low reset
//  Adr         out  XLEN   memory address
//  WriteData   out  XLEN   store data (B register)
//  ReadData    in   XLEN   memory read data, valid when MemAck=1
//  MemReq      out  1      access request = MemAccess & ~BusErr & reset
//  MemWe       out  1      write qualifier = MemReq & MemWrite
//  MemAck      in   1      access complete this cycle
//  Instr       out  XLEN   instruction register
//  ALUFlags    out  4      {N,Z,C,V} of current ALU result (combinational)
//  Stall       out  1      MemReq & ~MemAck
//  BusErr      out  1      sticky wait-timeout error
//  PCWrite, RegWrite, IRWrite, MemAccess, MemWrite, AdrSrc  in 1   controller strobes
//  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc  in 2   mux selects
//  ALUControl  in   3      ALU operation
// BEHAVIOUR
//  - Reset (reset=0): PC=RESET_PC; Instr, Data, A, B, ALUOut, regfile, wait counter and BusErr clear to 0.
//    MemReq, MemWe and Stall are 0 while reset=0, independent of the other inputs.
//  - Adr = AdrSrc ? Result : PC.
//  - RA1 = RegSrc[0] ? NREG-1 : Instr[19:16]. RA2 = RegSrc[1] ? Instr[15:12] : Instr[3:0].
//    Reads of reg NREG-1 return Result. Writes to it are dropped (PC is updated via PCWrite only).
//  - Regfile write address is Instr[15:12]. Write data is Result.
//  - SrcA: 00 A, 01 PC, 10 ALUOut, 11 zero. SrcB: 00 B, 01 ExtImm, 10 constant 4, 11 zero.
//  - ExtImm: 00 zext Instr[7:0]; 01 zext Instr[11:0]; 10 sext(Instr[23:0])<<2; 11 zero.
//  - Result: 00 ALUOut, 01 Data, 10 ALUResult, 11 zero.
//  - ALUControl: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MOV(SrcB); others give 0.
//  - Flags: N=msb; Z=all-zero. C = carry-out on ADD; C = NOT borrow on SUB. V = signed overflow on ADD/SUB.
//    C=V=0 for logic ops.
//  - Handshake: the controller holds MemAccess/MemWrite/AdrSrc stable until MemAck.
//    Stall is combinational. While Stall=1, every state register holds: PC, Instr, Data, A, B,
//    ALUOut and the regfile. PCWrite, IRWrite and RegWrite are gated by ~Stall.
//  - Instr loads on IRWrite & MemAck. Data loads on MemAccess & ~MemWrite & MemAck.
//    Otherwise Data holds.
//  - A, B and ALUOut load every non-stalled cycle. All updates take effect at the next rising edge (1-cycle latency).
//  - MemAck while MemReq=0 is ignored.
//  - Wait counter: increments each Stall cycle; clears on MemAck or when MemAccess=0.
//    When the counter reaches MAX_WAIT and MemAck=0, BusErr sets.
//    BusErr stays set until reset and forces MemReq=0 (hence Stall=0).
//    MemAck in the same cycle the counter reaches MAX_WAIT: the ack wins and BusErr stays 0.
//  - Reset asserted mid-access: MemReq drops combinationally. Any pending write is abandoned.
//  - PC arithmetic wraps modulo 2^XLEN.
// STRUCTURE
//  - Package mc_pkg: ALUControl, ImmSrc, ResultSrc and ALUSrcA/B encodings as localparams; the MAX_WAIT default.
//  - Sub-module mc_alu #(XLEN): op -> result + NZCV. Reuse the existing flopenr/mux2/mux3 for the registers and muxes.
// TESTING
//  - Reset: hold reset=0 with MemAccess=1 -> MemReq=0, PC=RESET_PC, Instr=0, BusErr=0.
//  - Zero-wait fetch: MemAccess=IRWrite=PCWrite=1, AdrSrc=0, SrcA=PC, SrcB=4, ResultSrc=10, MemAck same cycle,
//    ReadData=0xE2811005 -> next edge Instr=0xE2811005, PC=4.
//  - 3-wait fetch: MemAck low for 3 cycles -> Stall=1 for 3 cycles, PC/Instr unchanged; on the ack cycle Stall=0,
//    then the values update.
//  - Timeout: MAX_WAIT=15, no ack -> BusErr=1 after 15 stalled cycles, MemReq=0; ack on cycle 15 instead -> BusErr=0.
//  - ALU flags: A=0x7FFFFFFF, B=1, ADD -> NZCV=1001; A=B=5, SUB -> 0110; AND 0xF0 & 0x0F -> Z=1, C=V=0.
//  - Regfile: write R3=0x1234 via ResultSrc=10; read RA1=3 -> 0x1234; write to R15 ignored; R15 read returns Result.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle datapath: ALU operations, immediate
// formats, result/source mux selects and the default wait-state budget.
package mc_pkg;

    // ALU operation codes driven by the controller on ALUControl
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_MOV = 3'b101;

    // Immediate extension formats selected by ImmSrc
    localparam logic [1:0] IMM_ZX8  = 2'b00;
    localparam logic [1:0] IMM_ZX12 = 2'b01;
    localparam logic [1:0] IMM_BR   = 2'b10;
    localparam logic [1:0] IMM_ZERO = 2'b11;

    // Result bus sources selected by ResultSrc
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_ZERO   = 2'b11;

    // ALU operand A sources selected by ALUSrcA
    localparam logic [1:0] SRCA_A      = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;
    localparam logic [1:0] SRCA_ZERO   = 2'b11;

    // ALU operand B sources selected by ALUSrcB
    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
    localparam logic [1:0] SRCB_ZERO = 2'b11;

    // Stalled cycles tolerated per memory access before the bus error trips
    localparam int MAX_WAIT_DEFAULT = 15;

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU for the multicycle datapath: arithmetic, logic and move
// operations with ARM-style N/Z/C/V flags.
module mc_alu
    import mc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_srcA,
    input  logic [XLEN-1:0] i_srcB,
    input  logic [2:0]      i_aluControl,
    output logic [XLEN-1:0] o_result,
    output logic [3:0]      o_flags
);

    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_diff;
    logic [XLEN-1:0] w_result;
    logic            w_carry;
    logic            w_overflow;

    // Both adders are always evaluated; subtraction is A + ~B + 1 so its carry-out is NOT borrow
    always_comb begin
        w_sum  = {1'b0, i_srcA} + {1'b0, i_srcB};
        w_diff = {1'b0, i_srcA} + {1'b0, ~i_srcB} + {{XLEN{1'b0}}, 1'b1};
    end

    // Operation select; carry and overflow only mean something for ADD/SUB
    always_comb begin
        w_result   = '0;
        w_carry    = 1'b0;
        w_overflow = 1'b0;
        case (i_aluControl)
            ALU_ADD: begin
                w_result   = w_sum[XLEN-1:0];
                w_carry    = w_sum[XLEN];
                w_overflow = (i_srcA[XLEN-1] == i_srcB[XLEN-1]) &&
                             (w_sum[XLEN-1] != i_srcA[XLEN-1]);
            end
            ALU_SUB: begin
                w_result   = w_diff[XLEN-1:0];
                w_carry    = w_diff[XLEN];
                w_overflow = (i_srcA[XLEN-1] != i_srcB[XLEN-1]) &&
                             (w_diff[XLEN-1] != i_srcA[XLEN-1]);
            end
            ALU_AND: w_result = i_srcA & i_srcB;
            ALU_ORR: w_result = i_srcA | i_srcB;
            ALU_EOR: w_result = i_srcA ^ i_srcB;
            ALU_MOV: w_result = i_srcB;
            default: w_result = '0;
        endcase
    end

    // Pack the result and the {N,Z,C,V} flags
    always_comb begin
        o_result = w_result;
        o_flags  = {w_result[XLEN-1], (w_result == '0), w_carry, w_overflow};
    end

endmodule

// File: rtl/mc_datapath_ws.sv
// Multicycle ARM-subset datapath with a wait-state memory handshake.
// Holds PC, IR, data, A/B, ALUOut and the register file; freezes all state
// while memory is stalling and raises a sticky bus error on a wait timeout.
module mc_datapath_ws
    import mc_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREG     = 16,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] Adr,
    output logic [XLEN-1:0] WriteData,
    input  logic [XLEN-1:0] ReadData,
    output logic            MemReq,
    output logic            MemWe,
    input  logic            MemAck,
    output logic [XLEN-1:0] Instr,
    output logic [3:0]      ALUFlags,
    output logic            Stall,
    output logic            BusErr,
    input  logic            PCWrite,
    input  logic            RegWrite,
    input  logic            IRWrite,
    input  logic            MemAccess,
    input  logic            MemWrite,
    input  logic            AdrSrc,
    input  logic [1:0]      RegSrc,
    input  logic [1:0]      ALUSrcA,
    input  logic [1:0]      ALUSrcB,
    input  logic [1:0]      ResultSrc,
    input  logic [1:0]      ImmSrc,
    input  logic [2:0]      ALUControl
);

    localparam int RW = $clog2(NREG);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [RW-1:0] PC_IDX = RW'(NREG - 1);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_data;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_aluOut;
    logic [XLEN-1:0] r_regs [0:NREG-2];
    logic [CW-1:0]   r_waitCnt;
    logic            r_busErr;

    logic            w_memReq;
    logic            w_stall;
    logic            w_ack;
    logic [CW-1:0]   w_cntNext;
    logic [XLEN-1:0] w_extImm;
    logic [XLEN-1:0] w_srcA;
    logic [XLEN-1:0] w_srcB;
    logic [XLEN-1:0] w_aluResult;
    logic [XLEN-1:0] w_result;
    logic [RW-1:0]   w_ra1;
    logic [RW-1:0]   w_ra2;
    logic [RW-1:0]   w_wa;
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;
    logic            w_regWe;

    // Memory handshake: reset and a latched bus error both kill the request at once
    always_comb begin
        w_memReq  = MemAccess & ~r_busErr & reset;
        w_stall   = w_memReq & ~MemAck;
        w_ack     = w_memReq & MemAck;
        w_cntNext = r_waitCnt + 1'b1;
        MemReq    = w_memReq;
        MemWe     = w_memReq & MemWrite;
        Stall     = w_stall;
        BusErr    = r_busErr;
    end

    // Immediate extension; the branch form is a sign-extended word offset
    always_comb begin
        w_extImm = '0;
        case (ImmSrc)
            IMM_ZX8:  w_extImm = {{(XLEN-8){1'b0}}, r_instr[7:0]};
            IMM_ZX12: w_extImm = {{(XLEN-12){1'b0}}, r_instr[11:0]};
            IMM_BR:   w_extImm = XLEN'($signed({r_instr[23:0], 2'b00}));
            default:  w_extImm = '0;
        endcase
    end

    // ALU operand selection
    always_comb begin
        w_srcA = '0;
        case (ALUSrcA)
            SRCA_A:      w_srcA = r_a;
            SRCA_PC:     w_srcA = r_pc;
            SRCA_ALUOUT: w_srcA = r_aluOut;
            default:     w_srcA = '0;
        endcase
        w_srcB = '0;
        case (ALUSrcB)
            SRCB_B:    w_srcB = r_b;
            SRCB_IMM:  w_srcB = w_extImm;
            SRCB_FOUR: w_srcB = XLEN'(4);
            default:   w_srcB = '0;
        endcase
    end

    mc_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .i_srcA       (w_srcA),
        .i_srcB       (w_srcB),
        .i_aluControl (ALUControl),
        .o_result     (w_aluResult),
        .o_flags      (ALUFlags)
    );

    // Result bus and address mux; the Result bus also feeds PC and the register file
    always_comb begin
        w_result = '0;
        case (ResultSrc)
            RES_ALUOUT: w_result = r_aluOut;
            RES_DATA:   w_result = r_data;
            RES_ALU:    w_result = w_aluResult;
            default:    w_result = '0;
        endcase
        Adr       = AdrSrc ? w_result : r_pc;
        WriteData = r_b;
        Instr     = r_instr;
    end

    // Register file addressing; the top index aliases the PC and reads back the Result bus
    always_comb begin
        w_ra1   = RegSrc[0] ? PC_IDX : RW'(r_instr[19:16]);
        w_ra2   = RegSrc[1] ? RW'(r_instr[15:12]) : RW'(r_instr[3:0]);
        w_wa    = RW'(r_instr[15:12]);
        w_rd1   = (w_ra1 >= PC_IDX) ? w_result : r_regs[w_ra1];
        w_rd2   = (w_ra2 >= PC_IDX) ? w_result : r_regs[w_ra2];
        w_regWe = RegWrite & ~w_stall & (w_wa < PC_IDX);
    end

    // Register file write port; writes aimed at the PC alias are dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG - 1; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_regWe) begin
            r_regs[w_wa] <= w_result;
        end
    end

    // PC and instruction register; only a real acknowledge can load the IR
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc    <= RESET_PC;
            r_instr <= '0;
        end else begin
            if (PCWrite && !w_stall) begin
                r_pc <= w_result;
            end
            if (IRWrite && w_ack) begin
                r_instr <= ReadData;
            end
        end
    end

    // Data, A, B and ALUOut: data captures completed reads, the rest load every unstalled cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluOut <= '0;
        end else begin
            if (MemAccess && !MemWrite && w_ack) begin
                r_data <= ReadData;
            end
            if (!w_stall) begin
                r_a      <= w_rd1;
                r_b      <= w_rd2;
                r_aluOut <= w_aluResult;
            end
        end
    end

    // Wait counter and sticky bus error; an ack in the final allowed cycle removes the stall and wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_waitCnt <= '0;
            r_busErr  <= 1'b0;
        end else begin
            if (w_ack || !MemAccess) begin
                r_waitCnt <= '0;
            end else if (w_stall) begin
                r_waitCnt <= w_cntNext;
                if (w_cntNext == CW'(MAX_WAIT)) begin
                    r_busErr <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mc_datapath_ws.sv
// Directed self-checking bench for mc_datapath_ws: reset, fetch with and
// without wait states, ALU flags, register file, PC wrap and bus timeout.
module tb_mc_datapath_ws;
    import mc_pkg::*;

    logic        clk;
    logic        reset;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        MemReq;
    logic        MemWe;
    logic        MemAck;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        Stall;
    logic        BusErr;
    logic        PCWrite, RegWrite, IRWrite, MemAccess, MemWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]  ALUControl;

    int testsRun;
    int testsFailed;

    mc_datapath_ws #(
        .XLEN     (32),
        .NREG     (16),
        .RESET_PC (32'h0),
        .MAX_WAIT (15)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Adr        (Adr),
        .WriteData  (WriteData),
        .ReadData   (ReadData),
        .MemReq     (MemReq),
        .MemWe      (MemWe),
        .MemAck     (MemAck),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .Stall      (Stall),
        .BusErr     (BusErr),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .MemAccess  (MemAccess),
        .MemWrite   (MemWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl)
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drive every controller strobe and select in one go
    task automatic applyStimulus(input logic pcw, input logic regw, input logic irw,
                                 input logic macc, input logic mw, input logic adrs,
                                 input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                                 input logic [1:0] res, input logic [1:0] imm, input logic [2:0] alu);
        PCWrite    = pcw;
        RegWrite   = regw;
        IRWrite    = irw;
        MemAccess  = macc;
        MemWrite   = mw;
        AdrSrc     = adrs;
        RegSrc     = rs;
        ALUSrcA    = sa;
        ALUSrcB    = sb;
        ResultSrc  = res;
        ImmSrc     = imm;
        ALUControl = alu;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 2'b00, SRCA_A, SRCB_B, RES_ALUOUT, IMM_ZX8, ALU_ADD);
        MemAck = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Put the ALU result on Adr and check both the flags and the value
    task automatic aluCheck(input string tag, input logic [1:0] sa, input logic [1:0] sb,
                            input logic [1:0] imm, input logic [2:0] alu,
                            input logic [3:0] expFlags, input logic [31:0] expVal);
        applyStimulus(0, 0, 0, 0, 0, 1, 2'b00, sa, sb, RES_ALU, imm, alu);
        #2;
        checkOutput({tag, " flags"}, {28'h0, ALUFlags}, {28'h0, expFlags});
        checkOutput({tag, " value"}, Adr, expVal);
    endtask

    // Zero-wait data read into Data, then copy Data into PC
    task automatic loadPc(input logic [31:0] value);
        applyStimulus(0, 0, 0, 1, 0, 1, 2'b00, SRCA_ZERO, SRCB_ZERO, RES_ALU, IMM_ZX8, ALU_ADD);
        MemAck   = 1'b1;
        ReadData = value;
        tick();
        idle();
        applyStimulus(1, 0, 0, 0, 0, 0, 2'b00, SRCA_ZERO, SRCB_ZERO, RES_DATA, IMM_ZX8, ALU_ADD);
        tick();
        idle();
        #1;
        checkOutput("pc load", Adr, value);
    endtask

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main directed sequence
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset       = 1'b0;
        MemAck      = 1'b0;
        ReadData    = '0;

        // Reset with an access requested: the request must stay low
        applyStimulus(0, 0, 0, 1, 1, 0, 2'b00, SRCA_A, SRCB_B, RES_ALUOUT, IMM_ZX8, ALU_ADD);
        #2;
        checkOutput("rst MemReq", {31'h0, MemReq}, 32'h0);
        checkOutput("rst MemWe", {31'h0, MemWe}, 32'h0);
        checkOutput("rst Stall", {31'h0, Stall}, 32'h0);
        tick();
        checkOutput("rst PC", Adr, 32'h0);
        checkOutput("rst Instr", Instr, 32'h0);
        checkOutput("rst BusErr", {31'h0, BusErr}, 32'h0);
        idle();
        @(negedge clk);
        reset = 1'b1;

        // Zero-wait fetch
        applyStimulus(1, 0, 1, 1, 0, 0, 2'b00, SRCA_PC, SRCB_FOUR, RES_ALU, IMM_ZX8, ALU_ADD);
        MemAck   = 1'b1;
        ReadData = 32'hE2811005;
        #1;
        checkOutput("fetch0 Stall", {31'h0, Stall}, 32'h0);
        checkOutput("fetch0 MemReq", {31'h0, MemReq}, 32'h1);
        tick();
        idle();
        #1;
        checkOutput("fetch0 Instr", Instr, 32'hE2811005);
        checkOutput("fetch0 PC", Adr, 32'h4);

        // ALU flags with PC=4 and Instr=E2811005 (imm8 = 5)
        aluCheck("add small", SRCA_PC, SRCB_IMM, IMM_ZX8, ALU_ADD, 4'b0000, 32'h9);
        aluCheck("sub equal", SRCA_PC, SRCB_FOUR, IMM_ZX8, ALU_SUB, 4'b0110, 32'h0);
        aluCheck("sub borrow", SRCA_PC, SRCB_IMM, IMM_ZX8, ALU_SUB, 4'b1000, 32'hFFFFFFFF);
        aluCheck("and zero", SRCA_ZERO, SRCB_FOUR, IMM_ZX8, ALU_AND, 4'b0100, 32'h0);
        aluCheck("orr", SRCA_PC, SRCB_IMM, IMM_ZX8, ALU_ORR, 4'b0000, 32'h5);
        aluCheck("eor", SRCA_PC, SRCB_FOUR, IMM_ZX8, ALU_EOR, 4'b0100, 32'h0);
        aluCheck("mov brimm", SRCA_ZERO, SRCB_IMM, IMM_BR, ALU_MOV, 4'b1000, 32'hFE044014);
        aluCheck("mov imm12", SRCA_ZERO, SRCB_IMM, IMM_ZX12, ALU_MOV, 4'b0000, 32'h5);
        aluCheck("bad op", SRCA_PC, SRCB_FOUR, IMM_ZX8, 3'b111, 4'b0100, 32'h0);
        idle();

        // Fetch with three wait states
        @(negedge clk);
        applyStimulus(1, 0, 1, 1, 0, 0, 2'b00, SRCA_PC, SRCB_FOUR, RES_ALU, IMM_ZX8, ALU_ADD);
        MemAck   = 1'b0;
        ReadData = 32'hE0033003;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("wait Stall", {31'h0, Stall}, 32'h1);
            tick();
            checkOutput("wait PC hold", Adr, 32'h4);
            checkOutput("wait IR hold", Instr, 32'hE2811005);
        end
        MemAck = 1'b1;
        #1;
        checkOutput("ack Stall", {31'h0, Stall}, 32'h0);
        tick();
        idle();
        #1;
        checkOutput("wait3 Instr", Instr, 32'hE0033003);
        checkOutput("wait3 PC", Adr, 32'h8);

        // Register file: R3 <= 0x1234 through the ALU result path, then read it back
        loadPc(32'h00001234);
        applyStimulus(0, 1, 0, 0, 0, 0, 2'b00, SRCA_PC, SRCB_ZERO, RES_ALU, IMM_ZX8, ALU_ADD);
        tick();
        idle();
        tick();
        checkOutput("R3 via RA2", WriteData, 32'h00001234);
        applyStimulus(0, 0, 0, 0, 0, 1, 2'b00, SRCA_A, SRCB_ZERO, RES_ALU, IMM_ZX8, ALU_ADD);
        #1;
        checkOutput("R3 via RA1", Adr, 32'h00001234);

        // RA1 forced to the PC alias reads the Result bus (PC + 4)
        applyStimulus(0, 0, 0, 0, 0, 0, 2'b01, SRCA_PC, SRCB_FOUR, RES_ALU, IMM_ZX8, ALU_ADD);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 2'b00, SRCA_A, SRCB_ZERO, RES_ALU, IMM_ZX8, ALU_ADD);
        #1;
        checkOutput("R15 read", Adr, 32'h00001238);
        idle();

        // Signed overflow on ADD, then PC wrap through zero
        loadPc(32'h7FFFFFFF);
        aluCheck("add ovf", SRCA_PC, SRCB_FOUR, IMM_ZX8, ALU_ADD, 4'b1001, 32'h80000003);
        idle();
        loadPc(32'hFFFFFFFC);
        applyStimulus(1, 0, 0, 0, 0, 0, 2'b00, SRCA_PC, SRCB_FOUR, RES_ALU, IMM_ZX8, ALU_ADD);
        #1;
        checkOutput("wrap flags", {28'h0, ALUFlags}, 32'h6);
        tick();
        idle();
        #1;
        checkOutput("wrap PC", Adr, 32'h0);

        // Timeout: a write that is never acknowledged
        loadPc(32'h00000040);
        reset = 1'b0;
        #1;
        checkOutput("async rst PC", Adr, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 1, 1, 0, 2'b00, SRCA_A, SRCB_B, RES_ALUOUT, IMM_ZX8, ALU_ADD);
        #1;
        checkOutput("write MemWe", {31'h0, MemWe}, 32'h1);
        for (int i = 0; i < 15; i++) begin
            #1;
            checkOutput("to Stall", {31'h0, Stall}, 32'h1);
            checkOutput("to BusErr low", {31'h0, BusErr}, 32'h0);
            tick();
        end
        checkOutput("to BusErr", {31'h0, BusErr}, 32'h1);
        checkOutput("to MemReq", {31'h0, MemReq}, 32'h0);
        checkOutput("to Stall off", {31'h0, Stall}, 32'h0);
        checkOutput("to MemWe", {31'h0, MemWe}, 32'h0);

        // With BusErr set the request is dead, so an ack must not load the IR
        applyStimulus(0, 0, 1, 1, 0, 0, 2'b00, SRCA_A, SRCB_B, RES_ALUOUT, IMM_ZX8, ALU_ADD);
        MemAck   = 1'b1;
        ReadData = 32'hDEADBEEF;
        tick();
        idle();
        tick();
        checkOutput("ack ignored", Instr, 32'h0);
        checkOutput("BusErr sticky", {31'h0, BusErr}, 32'h1);

        // Ack on the 15th stalled cycle wins over the timeout
        reset = 1'b0;
        #1;
        @(negedge clk);
        reset = 1'b1;
        applyStimulus(0, 0, 1, 1, 0, 0, 2'b00, SRCA_PC, SRCB_FOUR, RES_ALU, IMM_ZX8, ALU_ADD);
        MemAck   = 1'b0;
        ReadData = 32'hE3A00000;
        for (int i = 0; i < 14; i++) begin
            tick();
        end
        MemAck = 1'b1;
        #1;
        checkOutput("late ack Stall", {31'h0, Stall}, 32'h0);
        tick();
        idle();
        #1;
        checkOutput("late ack BusErr", {31'h0, BusErr}, 32'h0);
        checkOutput("late ack Instr", Instr, 32'hE3A00000);

        // Reset asserted in the middle of a write drops the request immediately
        applyStimulus(0, 0, 0, 1, 1, 0, 2'b00, SRCA_A, SRCB_B, RES_ALUOUT, IMM_ZX8, ALU_ADD);
        #1;
        checkOutput("mid write MemWe", {31'h0, MemWe}, 32'h1);
        reset = 1'b0;
        #1;
        checkOutput("mid rst MemReq", {31'h0, MemReq}, 32'h0);
        checkOutput("mid rst MemWe", {31'h0, MemWe}, 32'h0);
        checkOutput("mid rst Stall", {31'h0, Stall}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
